uart_tx_param: RTL and testbench

- Parametrised successor to the team's fixed 8N1 UART transmitter.
- Configurable data width, parity and stop bits; includes an internal transmit FIFO with a valid/ready write handshake.
- Sits between any byte producer (control FSM, pulse/measurement logic) and the board's serial TX pin.
- Sends back-to-back frames with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_fifo.sv | 62 ++++++
 rtl/uart_tx_param.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : parity codes, FSM encoding, frame-length helper        |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Shared with the receiver so both ends decode the same encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int frame_cycles(input int div, input int data_bits,
                                      input int parity, input int stop_bits);
    return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_fifo : synchronous FIFO, registered count, show-ahead read   |
// | Rev 1.0   : initial release                                       |
// +------------------------------------------------------------------+
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx_param : parametrised UART transmitter with input FIFO     |
// | Rev 1.0       : initial release                                   |
// +------------------------------------------------------------------+
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV    = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W = $clog2(DIV);
  localparam int CNT_W  = $clog2(DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;
  logic                 baud_end;
  logic                 load;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (valid),
    .pop   (fifo_pop),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ready = !fifo_full;
  assign tx    = tx_q;
  assign busy  = busy_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    load     = 1'b0;
    fifo_pop = 1'b0;
    baud_end = (baud_q == BAUD_W'(DIV - 1));

    case (state_q)
      ST_IDLE: begin
        load = !fifo_empty;
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == CNT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == CNT_W'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            load    = !fifo_empty;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    // A pop from IDLE or from the last stop bit both start a full start bit.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout;
      par_d    = (PARITY == PARITY_ODD) ? ~^fifo_dout : ^fifo_dout;
      baud_d   = '0;
      bit_d    = '0;
      state_d  = ST_START;
    end

    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_q != ST_IDLE) || !fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx_param : three configurations against a line model      |
// | Rev 1.0          : initial release                                |
// +------------------------------------------------------------------+
module tb_uart_tx_param;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       v_drv = 1'b0;
  logic [8:0] d_drv = '0;

  logic [2:0] valid_w, tx_w, busy_w, ready_w;
  logic [2:0] cnt_w [3];

  int checks = 0;
  int errors = 0;

  int DB  [3] = '{8, 7, 8};
  int PAR [3] = '{0, 2, 1};
  int SB  [3] = '{1, 2, 1};

  logic [8:0] words [16];

  always #5 clk = ~clk;

  always_comb begin
    valid_w      = '0;
    valid_w[sel] = v_drv;
  end

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .data(d_drv[7:0]), .valid(valid_w[0]),
    .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .data(d_drv[6:0]), .valid(valid_w[1]),
    .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));

  uart_tx_param #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .data(d_drv[7:0]), .valid(valid_w[2]),
    .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));

  function automatic int frame_len(input int s);
    return (1 + DB[s] + ((PAR[s] != 0) ? 1 : 0) + SB[s]) * DIV;
  endfunction

  // Bit bi of the frame for word w: start, data LSB first, parity, stops.
  function automatic logic frame_bit(input int s, input logic [8:0] w, input int bi);
    int ones;
    ones = 0;
    for (int i = 0; i < DB[s]; i++) ones += int'(w[i]);
    if (bi == 0) return 1'b0;
    if (bi <= DB[s]) return w[bi-1];
    if (PAR[s] != 0 && bi == DB[s] + 1)
      return (PAR[s] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
    return 1'b1;
  endfunction

  task automatic wait_idle(input logic [1:0] s);
    int n;
    sel = s;
    v_drv = 1'b0;
    n = 0;
    while (busy_w[s] !== 1'b0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy_w[s] !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle inst %0d busy got %b want 0 after %0d cycles", s, busy_w[s], n);
    end
  endtask

  // Greedy producer pushes words[0..n-1]; paced producer keeps about two queued
  // and pushes on pop edges so push and pop coincide at occupancy 2.
  task automatic run_stream(input logic [1:0] s, input int n, input bit paced,
                            input string name);
    int fl, acc, p, pops, exp_cnt, t;
    logic exp_tx, exp_busy, exp_rdy, rdy_s;
    logic [2:0] exp_c;
    fl = frame_len(s);
    sel = s;
    acc = 0;
    p = 0;
    rdy_s = ready_w[s];
    v_drv = 1'b1;
    d_drv = words[0];
    for (int k = 0; k <= 2 + fl*n + 3; k++) begin
      @(posedge clk); #1;
      if (v_drv && rdy_s) begin
        acc++;
        p++;
      end
      pops = 0;
      for (int j = 0; j < n; j++) if (1 + fl*j <= k) pops++;
      exp_cnt  = acc - pops;
      exp_c    = exp_cnt[2:0];
      exp_rdy  = (exp_cnt != 4);
      exp_busy = (k >= 1) && (k < 2 + fl*n);
      t = k - 2;
      if (t < 0 || t / fl >= n) exp_tx = 1'b1;
      else exp_tx = frame_bit(s, words[t / fl], (t % fl) / DIV);

      checks += 4;
      if (tx_w[s] !== exp_tx) begin
        errors++;
        $display("FAIL %s tx edge %0d got %b want %b", name, k, tx_w[s], exp_tx);
      end
      if (busy_w[s] !== exp_busy) begin
        errors++;
        $display("FAIL %s busy edge %0d got %b want %b", name, k, busy_w[s], exp_busy);
      end
      if (cnt_w[s] !== exp_c) begin
        errors++;
        $display("FAIL %s fifo_count edge %0d got %0d want %0d", name, k, cnt_w[s], exp_c);
      end
      if (ready_w[s] !== exp_rdy) begin
        errors++;
        $display("FAIL %s ready edge %0d got %b want %b", name, k, ready_w[s], exp_rdy);
      end

      rdy_s = ready_w[s];
      v_drv = (p < n) && (!paced || cnt_w[s] < 3'd2 || (k % fl == 0 && k / fl < n));
      // Words offered while not ready must be ignored, so offer junk then.
      d_drv = (v_drv && rdy_s) ? words[p] : 9'($urandom);
    end
    v_drv = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks += 4;
      if (tx_w[s] !== 1'b1 || busy_w[s] !== 1'b0 || ready_w[s] !== 1'b1 || cnt_w[s] !== 3'd0) begin
        errors++;
        $display("FAIL reset inst %0d tx/busy/ready/count got %b/%b/%b/%0d want 1/0/1/0",
                 s, tx_w[s], busy_w[s], ready_w[s], cnt_w[s]);
      end
    end
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (tx_w[s] !== 1'b1 || busy_w[s] !== 1'b0) begin
        errors++;
        $display("FAIL post_reset inst %0d tx/busy got %b/%b want 1/0", s, tx_w[s], busy_w[s]);
      end
    end
  endtask

  task automatic test_single_8n1;
    wait_idle(2'd0);
    words[0] = 9'h0A5;
    run_stream(2'd0, 1, 1'b0, "single_8n1");
  endtask

  task automatic test_parity_even;
    wait_idle(2'd1);
    words[0] = 9'h035;
    run_stream(2'd1, 1, 1'b0, "parity_even_7e2");
  endtask

  task automatic test_parity_odd;
    wait_idle(2'd2);
    words[0] = 9'h000;
    run_stream(2'd2, 1, 1'b0, "parity_odd_zero");
  endtask

  task automatic test_fifo_full;
    wait_idle(2'd0);
    for (int i = 0; i < 5; i++) words[i] = 9'(i + 1);
    run_stream(2'd0, 5, 1'b0, "fifo_full");
  endtask

  task automatic test_push_pop_wrap;
    wait_idle(2'd0);
    for (int i = 0; i < 6; i++) words[i] = 9'($urandom_range(0, 255));
    run_stream(2'd0, 6, 1'b1, "push_pop_wrap");
  endtask

  task automatic test_back_to_back;
    for (int s = 0; s < 3; s++) begin
      wait_idle(2'(s));
      for (int i = 0; i < 5; i++) words[i] = 9'($urandom_range(0, (1 << DB[s]) - 1));
      run_stream(2'(s), 5, 1'b0, "back_to_back");
    end
  endtask

  task automatic test_reset_midframe;
    int bad;
    wait_idle(2'd0);
    v_drv = 1'b1;
    d_drv = 9'h000;
    @(posedge clk); #1;
    d_drv = 9'h0FF;
    @(posedge clk); #1;
    v_drv = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    checks += 2;
    if (tx_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_pre tx got %b want 0", tx_w[0]);
    end
    if (cnt_w[0] !== 3'd1) begin
      errors++;
      $display("FAIL midframe_pre fifo_count got %0d want 1", cnt_w[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (tx_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_rst tx got %b want 1", tx_w[0]);
    end
    if (cnt_w[0] !== 3'd0) begin
      errors++;
      $display("FAIL midframe_rst fifo_count got %0d want 0", cnt_w[0]);
    end
    if (ready_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_rst ready got %b want 1", ready_w[0]);
    end
    if (busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_rst busy got %b want 0", busy_w[0]);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midframe_after line active on %0d cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset;
    test_single_8n1;
    test_parity_even;
    test_parity_odd;
    test_fifo_full;
    test_push_pop_wrap;
    test_back_to_back;
    test_reset_midframe;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
